// File: rtl/branch_target_unit.sv
// Fetch-stage branch resolver: loadable target table, condition evaluation,
// return-address stack, one-cycle registered redirect and taken-branch counter.
module branch_target_unit #(
    parameter int D   = 12,
    parameter int A   = 5,
    parameter int RSD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          br_valid,
    input  logic [2:0]    br_op,
    input  logic [A-1:0]  br_idx,
    input  logic          zero,
    input  logic          sign,
    input  logic [D-1:0]  prog_ctr,
    input  logic          wr_en,
    input  logic [A-1:0]  wr_idx,
    input  logic          wr_rel,
    input  logic [D-1:0]  wr_value,
    output logic          absj,
    output logic [D-1:0]  target,
    output logic          ras_err,
    output logic [15:0]   taken_count
);
    localparam int N  = 2**A;
    localparam int PW = (RSD > 1) ? $clog2(RSD) : 1;
    localparam int CW = $clog2(RSD + 1);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t                 state;
    logic [N-1:0]           tbl_rel;
    logic [N-1:0][D-1:0]    tbl_val;
    logic [RSD-1:0][D-1:0]  ras;
    logic [PW-1:0]          sp;       // next free slot; top of stack is sp-1
    logic [CW-1:0]          ras_cnt;

    logic [PW-1:0]          sp_inc, sp_dec;
    logic [D-1:0]           tbl_tgt, nxt_tgt;
    logic                   accept, cond, is_push, is_pop, ret_empty;
    logic                   taken, push, pop, err;

    // The wrong-path slot behind a redirect is never evaluated.
    assign accept = br_valid && (state == IDLE);
    assign absj   = (state == REDIRECT);

    always_comb begin
        sp_inc    = (sp == PW'(RSD - 1)) ? '0 : sp + 1'b1;
        sp_dec    = (sp == '0) ? PW'(RSD - 1) : sp - 1'b1;
        tbl_tgt   = tbl_rel[br_idx] ? prog_ctr + tbl_val[br_idx] : tbl_val[br_idx];
        nxt_tgt   = tbl_tgt;
        cond      = 1'b0;
        is_push   = 1'b0;
        is_pop    = 1'b0;
        ret_empty = 1'b0;
        case (br_op)
            3'b000:  cond = 1'b0;
            3'b001:  cond = 1'b1;
            3'b010:  cond = !sign || zero;
            3'b011:  cond = sign || zero;
            3'b100:  cond = zero;
            3'b101:  cond = !zero;
            3'b110: begin
                cond    = 1'b1;
                is_push = 1'b1;
            end
            default: begin
                if (ras_cnt == '0) begin
                    ret_empty = 1'b1;
                end else begin
                    cond    = 1'b1;
                    is_pop  = 1'b1;
                    nxt_tgt = ras[sp_dec];
                end
            end
        endcase
        taken = accept && cond;
        push  = accept && is_push;
        pop   = accept && is_pop;
        err   = accept && ret_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            target      <= '0;
            ras_err     <= 1'b0;
            taken_count <= '0;
            tbl_rel     <= '0;
            tbl_val     <= '0;
            ras         <= '0;
            sp          <= '0;
            ras_cnt     <= '0;
        end else begin
            ras_err <= err;
            if (taken) begin
                state  <= REDIRECT;
                target <= nxt_tgt;
                if (taken_count != 16'hFFFF)
                    taken_count <= taken_count + 16'd1;
            end else begin
                state  <= IDLE;
                target <= '0;
            end
            // Table reads above see the pre-write entry on a same-index collision.
            if (wr_en) begin
                tbl_rel[wr_idx] <= wr_rel;
                tbl_val[wr_idx] <= wr_value;
            end
            // A push on a full stack overwrites the oldest slot; count pins at RSD.
            if (push) begin
                ras[sp] <= prog_ctr + D'(1);
                sp      <= sp_inc;
                if (ras_cnt != CW'(RSD))
                    ras_cnt <= ras_cnt + 1'b1;
            end else if (pop) begin
                sp      <= sp_dec;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit: directed scenarios plus random
// traffic compared against a transaction-level model (table array, stack queue).
module tb_branch_target_unit;
    localparam int D   = 12;
    localparam int A   = 5;
    localparam int RSD = 4;
    localparam int N   = 2**A;

    logic          clk = 1'b0;
    logic          reset, br_valid, zero, sign, wr_en, wr_rel;
    logic [2:0]    br_op;
    logic [A-1:0]  br_idx, wr_idx;
    logic [D-1:0]  prog_ctr, wr_value;
    logic          absj, ras_err;
    logic [D-1:0]  target;
    logic [15:0]   taken_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit           m_rel [N];
    logic [D-1:0] m_val [N];
    logic [D-1:0] ras_q [$];
    int           m_cnt = 0;
    logic         m_absj = 1'b0;
    logic [D-1:0] m_tgt = '0;
    logic         m_err = 1'b0;

    branch_target_unit #(.D(D), .A(A), .RSD(RSD)) dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
        .br_idx(br_idx), .zero(zero), .sign(sign), .prog_ctr(prog_ctr),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_rel(wr_rel), .wr_value(wr_value),
        .absj(absj), .target(target), .ras_err(ras_err), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic clr_in();
        reset = 1'b0; br_valid = 1'b0; br_op = '0; br_idx = '0; zero = 1'b0;
        sign = 1'b0; prog_ctr = '0; wr_en = 1'b0; wr_idx = '0; wr_rel = 1'b0; wr_value = '0;
    endtask

    task automatic br(input logic [2:0] op, input logic [A-1:0] idx,
                      input logic [D-1:0] pc, input logic z, input logic s);
        br_valid = 1'b1; br_op = op; br_idx = idx; prog_ctr = pc; zero = z; sign = s;
    endtask

    task automatic wr(input logic [A-1:0] idx, input logic rel, input logic [D-1:0] val);
        wr_en = 1'b1; wr_idx = idx; wr_rel = rel; wr_value = val;
    endtask

    // Evaluate the model on the current inputs, clock once, publish expectations.
    task automatic tick();
        logic tk, e;
        logic [D-1:0] t;
        tk = 1'b0; e = 1'b0; t = '0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin m_rel[i] = 1'b0; m_val[i] = '0; end
            ras_q.delete();
            m_cnt = 0;
        end else begin
            if (br_valid && !m_absj) begin
                t = m_rel[br_idx] ? prog_ctr + m_val[br_idx] : m_val[br_idx];
                case (br_op)
                    3'd0: tk = 1'b0;
                    3'd1: tk = 1'b1;
                    3'd2: tk = !sign || zero;
                    3'd3: tk = sign || zero;
                    3'd4: tk = zero;
                    3'd5: tk = !zero;
                    3'd6: begin
                        tk = 1'b1;
                        ras_q.push_back(prog_ctr + D'(1));
                        if (ras_q.size() > RSD) void'(ras_q.pop_front());
                    end
                    default: begin
                        if (ras_q.size() == 0) e = 1'b1;
                        else begin tk = 1'b1; t = ras_q.pop_back(); end
                    end
                endcase
                if (tk && m_cnt < 65535) m_cnt++;
            end
            if (wr_en) begin m_rel[wr_idx] = wr_rel; m_val[wr_idx] = wr_value; end
        end
        @(posedge clk); #1;
        m_absj = tk;
        m_tgt  = tk ? t : '0;
        m_err  = e;
        clr_in();
    endtask

    task automatic test_reset();
        clr_in(); reset = 1'b1; tick();
        reset = 1'b1; tick();
        checks++;
        if (absj !== 1'b0 || target !== '0 || ras_err !== 1'b0 || taken_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: absj=%0b target=%0h ras_err=%0b cnt=%0d, want all 0",
                     absj, target, ras_err, taken_count);
        end
    endtask

    task automatic test_absolute();
        wr(1, 1'b0, 12'd42); tick();
        br(3'b001, 1, 12'h300, 0, 0); tick();
        checks++;
        if (absj !== 1'b1 || target !== 12'd42) begin
            errors++; $display("FAIL abs_taken: absj=%0b target=%0h, want 1/02a", absj, target);
        end
        tick();
        checks++;
        if (absj !== 1'b0 || target !== 12'd0) begin
            errors++; $display("FAIL abs_drop: absj=%0b target=%0h, want 0/000", absj, target);
        end
    endtask

    task automatic test_relative();
        wr(2, 1'b1, 12'hFFB); tick();
        br(3'b001, 2, 12'h004, 0, 0); tick();
        checks++;
        if (absj !== 1'b1 || target !== 12'hFFF) begin
            errors++; $display("FAIL rel_wrap: absj=%0b target=%0h, want 1/fff", absj, target);
        end
        tick();
        br(3'b001, 2, 12'h00A, 0, 0); tick();
        checks++;
        if (absj !== 1'b1 || target !== 12'h005) begin
            errors++; $display("FAIL rel_carry: absj=%0b target=%0h, want 1/005", absj, target);
        end
        tick();
    endtask

    task automatic test_conditions();
        // {op, zero, sign, expected taken}
        logic [5:0] vec [8];
        vec[0] = {3'b010, 1'b0, 1'b1, 1'b0};
        vec[1] = {3'b010, 1'b1, 1'b1, 1'b1};
        vec[2] = {3'b011, 1'b0, 1'b0, 1'b0};
        vec[3] = {3'b011, 1'b0, 1'b1, 1'b1};
        vec[4] = {3'b100, 1'b1, 1'b0, 1'b1};
        vec[5] = {3'b100, 1'b0, 1'b1, 1'b0};
        vec[6] = {3'b101, 1'b0, 1'b0, 1'b1};
        vec[7] = {3'b101, 1'b1, 1'b0, 1'b0};
        wr(3, 1'b0, 12'h123); tick();
        for (int i = 0; i < 8; i++) begin
            br(vec[i][5:3], 3, 12'h050, vec[i][2], vec[i][1]); tick();
            checks++;
            if (absj !== vec[i][0] || target !== (vec[i][0] ? 12'h123 : 12'h000)) begin
                errors++;
                $display("FAIL cond_%0d: op=%0d absj=%0b target=%0h, want absj=%0b",
                         i, vec[i][5:3], absj, target, vec[i][0]);
            end
            tick();
        end
    endtask

    task automatic test_write_collision();
        wr(1, 1'b0, 12'h077); br(3'b001, 1, 12'h000, 0, 0); tick();
        checks++;
        if (absj !== 1'b1 || target !== 12'd42) begin
            errors++; $display("FAIL wr_old_entry: target=%0h, want 02a", target);
        end
        tick();
        br(3'b001, 1, 12'h000, 0, 0); tick();
        checks++;
        if (target !== 12'h077) begin
            errors++; $display("FAIL wr_new_entry: target=%0h, want 077", target);
        end
        tick();
    endtask

    task automatic test_squash();
        int c0;
        c0 = taken_count;
        br(3'b001, 1, 12'h000, 0, 0); tick();
        br(3'b001, 2, 12'h004, 0, 0); tick();
        checks++;
        if (absj !== 1'b0 || target !== 12'h000 || taken_count !== 16'(c0 + 1)) begin
            errors++;
            $display("FAIL squash: absj=%0b target=%0h cnt=%0d, want 0/000/%0d",
                     absj, target, taken_count, c0 + 1);
        end
    endtask

    task automatic test_ras();
        br(3'b110, 1, 12'h010, 0, 0); tick(); tick();
        br(3'b111, 0, 12'h020, 0, 0); tick();
        checks++;
        if (absj !== 1'b1 || target !== 12'h011) begin
            errors++; $display("FAIL ras_call_ret: absj=%0b target=%0h, want 1/011", absj, target);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            br(3'b110, 1, 12'h100 + 12'(i), 0, 0); tick(); tick();
        end
        for (int i = 0; i < 4; i++) begin
            br(3'b111, 5, 12'h200, 1, 1); tick();
            checks++;
            if (absj !== 1'b1 || target !== 12'h105 - 12'(i) || ras_err !== 1'b0) begin
                errors++;
                $display("FAIL ras_pop_%0d: absj=%0b target=%0h err=%0b, want 1/%0h/0",
                         i, absj, target, ras_err, 12'h105 - 12'(i));
            end
            tick();
        end
        br(3'b111, 5, 12'h200, 0, 0); tick();
        checks++;
        if (absj !== 1'b0 || ras_err !== 1'b1 || target !== 12'h000) begin
            errors++; $display("FAIL ras_empty: absj=%0b err=%0b, want 0/1", absj, ras_err);
        end
        tick();
        checks++;
        if (ras_err !== 1'b0) begin
            errors++; $display("FAIL ras_err_pulse: err=%0b, want 0", ras_err);
        end
    endtask

    task automatic test_reset_mid();
        br(3'b001, 2, 12'h004, 0, 0); tick();
        reset = 1'b1; br(3'b001, 1, 12'h000, 0, 0); wr(4, 1'b1, 12'h111); tick();
        checks++;
        if (absj !== 1'b0 || target !== '0 || ras_err !== 1'b0 || taken_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: absj=%0b target=%0h err=%0b cnt=%0d, want all 0",
                     absj, target, ras_err, taken_count);
        end
        br(3'b001, 2, 12'h004, 0, 0); tick();
        checks++;
        if (absj !== 1'b1 || target !== 12'h000 || taken_count !== 16'd1) begin
            errors++;
            $display("FAIL table_cleared: absj=%0b target=%0h cnt=%0d, want 1/000/1",
                     absj, target, taken_count);
        end
        tick();
        br(3'b111, 0, 12'h000, 0, 0); tick();
        checks++;
        if (ras_err !== 1'b1 || absj !== 1'b0) begin
            errors++; $display("FAIL stack_cleared: err=%0b absj=%0b, want 1/0", ras_err, absj);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7)
                br(3'($urandom_range(0, 7)), A'($urandom_range(0, 7)), D'($urandom),
                   1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                wr(A'($urandom_range(0, 7)), 1'($urandom), D'($urandom));
            tick();
            checks++;
            if (absj !== m_absj || target !== m_tgt || ras_err !== m_err ||
                taken_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random_%0d: got %0b/%0h/%0b/%0d, want %0b/%0h/%0b/%0d", i,
                         absj, target, ras_err, taken_count, m_absj, m_tgt, m_err, m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        n = 2 * (65535 - m_cnt) + 20;
        for (int i = 0; i < n; i++) begin
            br(3'b001, 1, 12'h000, 0, 0); tick();
        end
        checks++;
        if (taken_count !== 16'hFFFF) begin
            errors++; $display("FAIL saturate: cnt=%0h, want ffff", taken_count);
        end
        br(3'b001, 1, 12'h000, 0, 0); tick(); tick();
        br(3'b001, 1, 12'h000, 0, 0); tick();
        checks++;
        if (taken_count !== 16'hFFFF || absj !== 1'b1) begin
            errors++; $display("FAIL saturate_hold: cnt=%0h absj=%0b, want ffff/1", taken_count, absj);
        end
    endtask

    initial begin
        clr_in();
        test_reset();
        test_absolute();
        test_relative();
        test_conditions();
        test_write_collision();
        test_squash();
        test_ras();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
